// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: chooses the next fetch address and
// generates flush and halt control for the IF/ID stages.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic [31:0] ex_pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [26:0] jump_field,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        halt,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        flush,
    output logic [31:0] link_addr,
    output logic        halted,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [3:0]  flush_cnt_reg;
    logic [3:0]  flush_cnt_next;

    logic        redirect_req;
    logic [31:0] redirect_target;
    logic [31:0] jump_target;
    logic        pc_advance;

    assign jump_target = {ex_pc[31:27], jump_field};
    assign redirect_req = jr | jump | br_taken;
    assign pc_advance = ~stall & imem_ready;

    // jr has priority over jump, which has priority over a taken branch.
    always_comb begin
        redirect_target = br_target;
        if (jr) begin
            redirect_target = jr_target;
        end else if (jump) begin
            redirect_target = jump_target;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        flush_cnt_next = flush_cnt_reg;
        case (state_reg)
            ST_BOOT: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                // A redirect overrides stall and imem backpressure.
                if (halt) begin
                    state_next = ST_HALT;
                end else if (redirect_req) begin
                    state_next     = ST_REDIRECT;
                    pc_next        = redirect_target;
                    flush_cnt_next = FLUSH_LOAD;
                end else if (pc_advance) begin
                    pc_next = pc_reg + 32'd1;
                end
            end
            ST_REDIRECT: begin
                // EX holds a bubble here, so redirect and halt inputs are ignored.
                if (flush_cnt_reg <= 4'd1) begin
                    state_next     = ST_FETCH;
                    flush_cnt_next = 4'd0;
                end else begin
                    flush_cnt_next = flush_cnt_reg - 4'd1;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= ST_BOOT;
            pc_reg        <= RESET_VECTOR;
            flush_cnt_reg <= 4'd0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    assign pc          = pc_reg;
    assign state       = state_reg;
    assign fetch_valid = (state_reg == ST_FETCH);
    assign flush       = (state_reg == ST_REDIRECT);
    assign halted      = (state_reg == ST_HALT);
    assign link_addr   = ex_pc + 32'd1;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, a halt sequence, then
// random traffic checked against a rule-level reference model.
module tb_pc_sequencer;

    localparam int FLUSH_CYCLES = 2;
    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset, stall, imem_ready, br_taken, jump, jr, halt;
    logic [31:0] ex_pc, br_target, jr_target;
    logic [26:0] jump_field;
    logic [31:0] pc, link_addr;
    logic        fetch_valid, flush, halted;
    logic [1:0]  state;

    int total = 0;
    int bad = 0;

    pc_sequencer #(.RESET_VECTOR(RV), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clock(clock), .reset(reset), .stall(stall), .imem_ready(imem_ready),
        .ex_pc(ex_pc), .br_taken(br_taken), .br_target(br_target),
        .jump(jump), .jump_field(jump_field), .jr(jr), .jr_target(jr_target),
        .halt(halt), .pc(pc), .fetch_valid(fetch_valid), .flush(flush),
        .link_addr(link_addr), .halted(halted), .state(state)
    );

    always #5 clock = ~clock;

    // Reference model: mode 0 boot, 1 fetch, 2 redirect, 3 halt;
    // m_left counts flush cycles still to be shown.
    int          m_mode = 0;
    logic [31:0] m_pc = RV;
    int          m_left = 0;

    task automatic model_edge();
        if (!reset) begin
            m_mode = 0; m_pc = RV; m_left = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (halt) m_mode = 3;
            else if (jr || jump || br_taken) begin
                if (jr) m_pc = jr_target;
                else if (jump) m_pc = (ex_pc & 32'hF800_0000) | {5'd0, jump_field};
                else m_pc = br_target;
                m_mode = 2;
                m_left = FLUSH_CYCLES;
            end else if (!stall && imem_ready) m_pc = m_pc + 1;
        end else if (m_mode == 2) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic rst, input logic stl, input logic rdy, input logic hlt,
                          input logic jr_i, input logic jmp, input logic br,
                          input logic [31:0] expc, input logic [26:0] jf,
                          input logic [31:0] brt, input logic [31:0] jrt);
        reset = rst; stall = stl; imem_ready = rdy; halt = hlt;
        jr = jr_i; jump = jmp; br_taken = br;
        ex_pc = expc; jump_field = jf; br_target = brt; jr_target = jrt;
    endtask

    typedef struct {
        logic        rst, stl, rdy, hlt, jr_i, jmp, br;
        logic [31:0] expc;
        logic [26:0] jf;
        logic [31:0] brt, jrt;
        logic [31:0] e_pc;
        logic [1:0]  e_st;
        logic        e_fl, e_hl;
        logic [31:0] e_link;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_b[$];

    function automatic vec_t mk(input logic rst, input logic stl, input logic rdy, input logic hlt,
                                input logic jr_i, input logic jmp, input logic br,
                                input logic [31:0] expc, input logic [26:0] jf,
                                input logic [31:0] brt, input logic [31:0] jrt,
                                input logic [31:0] e_pc, input logic [1:0] e_st,
                                input logic e_fl, input logic e_hl, input logic [31:0] e_link);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rdy = rdy; v.hlt = hlt;
        v.jr_i = jr_i; v.jmp = jmp; v.br = br;
        v.expc = expc; v.jf = jf; v.brt = brt; v.jrt = jrt;
        v.e_pc = e_pc; v.e_st = e_st; v.e_fl = e_fl; v.e_hl = e_hl; v.e_link = e_link;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        set_in(v.rst, v.stl, v.rdy, v.hlt, v.jr_i, v.jmp, v.br, v.expc, v.jf, v.brt, v.jrt);
        tick();
        chk({tag, " pc"}, pc, v.e_pc);
        chk({tag, " state"}, {30'd0, state}, {30'd0, v.e_st});
        chk({tag, " flush"}, {31'd0, flush}, {31'd0, v.e_fl});
        chk({tag, " fetch_valid"}, {31'd0, fetch_valid}, {31'd0, (v.e_st == 2'd1)});
        chk({tag, " halted"}, {31'd0, halted}, {31'd0, v.e_hl});
        chk({tag, " link_addr"}, link_addr, v.e_link);
        $display("vec %s: pc=%h state=%0d flush=%0d fv=%0d halted=%0d",
                 tag, pc, state, flush, fetch_valid, halted);
    endtask

    initial begin
        localparam logic [31:0] JPC = 32'hF800_0010;
        localparam logic [31:0] JT  = 32'hFA01_2529;
        localparam logic [31:0] JL  = 32'hF800_0011;
        // Boot: three reset cycles, then BOOT visible once, then pc 0..3.
        tab_a.push_back(mk(0,0,1,0,0,0,0, 0,0,0,0, 32'h0, 0,0,0, 32'h1));
        tab_a.push_back(mk(0,0,1,0,0,0,0, 0,0,0,0, 32'h0, 0,0,0, 32'h1));
        tab_a.push_back(mk(0,0,1,0,0,0,0, 0,0,0,0, 32'h0, 0,0,0, 32'h1));
        tab_a.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0, 32'h0, 1,0,0, 32'h1));
        tab_a.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0, 32'h1, 1,0,0, 32'h1));
        tab_a.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0, 32'h2, 1,0,0, 32'h1));
        tab_a.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0, 32'h3, 1,0,0, 32'h1));
        // J-type formation and two flush cycles.
        tab_a.push_back(mk(1,0,1,0,0,1,0, JPC,27'h2012529,0,0, JT, 2,1,0, JL));
        tab_a.push_back(mk(1,0,1,0,0,0,0, JPC,27'h2012529,0,0, JT, 2,1,0, JL));
        tab_a.push_back(mk(1,0,1,0,0,0,0, JPC,27'h2012529,0,0, JT, 1,0,0, JL));
        tab_a.push_back(mk(1,0,1,0,0,0,0, JPC,27'h2012529,0,0, JT+1, 1,0,0, JL));
        // jr beats jump and branch, and overrides stall.
        tab_a.push_back(mk(1,1,1,0,1,1,1, 0,27'h5,32'h200,32'h100, 32'h100, 2,1,0, 32'h1));
        tab_a.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0, 32'h100, 2,1,0, 32'h1));
        tab_a.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0, 32'h100, 1,0,0, 32'h1));
        // Stall four cycles, imem not ready two cycles, then resume.
        for (int i = 0; i < 4; i++)
            tab_a.push_back(mk(1,1,1,0,0,0,0, 0,0,0,0, 32'h100, 1,0,0, 32'h1));
        for (int i = 0; i < 2; i++)
            tab_a.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0, 32'h100, 1,0,0, 32'h1));
        tab_a.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0, 32'h101, 1,0,0, 32'h1));
        tab_a.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0, 32'h102, 1,0,0, 32'h1));
        // Wrap from all-ones to zero.
        tab_a.push_back(mk(1,0,1,0,1,0,0, 0,0,0,32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,1,0, 32'h1));
        tab_a.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0, 32'hFFFF_FFFF, 2,1,0, 32'h1));
        tab_a.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0, 32'hFFFF_FFFF, 1,0,0, 32'h1));
        tab_a.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0, 32'h0, 1,0,0, 32'h1));
        // Branch during REDIRECT is ignored and does not restart the count.
        tab_a.push_back(mk(1,0,1,0,0,0,1, 0,0,32'h50,0, 32'h50, 2,1,0, 32'h1));
        tab_a.push_back(mk(1,0,1,0,0,0,1, 0,0,32'h999,0, 32'h50, 2,1,0, 32'h1));
        tab_a.push_back(mk(1,0,1,0,0,0,1, 0,0,32'h999,0, 32'h50, 1,0,0, 32'h1));
        tab_a.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0, 32'h51, 1,0,0, 32'h1));
        // Halt.
        tab_a.push_back(mk(1,0,1,1,0,0,0, 0,0,0,0, 32'h51, 3,0,1, 32'h1));

        tab_b.push_back(mk(0,0,1,0,0,0,0, 0,0,0,0, RV, 0,0,0, 32'h1));
        tab_b.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0, RV, 1,0,0, 32'h1));
        tab_b.push_back(mk(1,0,1,0,0,1,0, 0,27'h40,0,0, 32'h40, 2,1,0, 32'h1));
        tab_b.push_back(mk(0,0,1,0,0,1,0, 0,27'h40,0,0, RV, 0,0,0, 32'h1));
        tab_b.push_back(mk(1,0,1,0,0,0,0, 0,0,0,0, RV, 1,0,0, 32'h1));

        set_in(0,0,1,0,0,0,0, 0,0,0,0);
        @(negedge clock);

        foreach (tab_a[i]) apply(tab_a[i], $sformatf("a%0d", i));

        // Frozen in HALT for 20 cycles despite jump pulses.
        for (int i = 0; i < 20; i++) begin
            set_in(1,0,1,0,0,(i % 2 == 0),0, 32'h0, 27'h777, 0, 0);
            tick();
            chk($sformatf("halt%0d pc", i), pc, 32'h51);
            chk($sformatf("halt%0d state", i), {30'd0, state}, 32'd3);
            chk($sformatf("halt%0d halted", i), {31'd0, halted}, 32'd1);
            chk($sformatf("halt%0d fv_flush", i), {30'd0, fetch_valid, flush}, 32'd0);
            $display("halt cycle %0d: pc=%h state=%0d", i, pc, state);
        end

        foreach (tab_b[i]) apply(tab_b[i], $sformatf("b%0d", i));

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            r = $urandom;
            set_in(($urandom_range(0, 60) != 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 4) != 0), ($urandom_range(0, 150) == 0),
                   ($urandom_range(0, 15) == 0), ($urandom_range(0, 12) == 0),
                   ($urandom_range(0, 9) == 0), r, 27'($urandom),
                   $urandom, $urandom);
            tick();
            chk($sformatf("rnd%0d pc", i), pc, m_pc);
            chk($sformatf("rnd%0d state", i), {30'd0, state}, 32'(m_mode));
            chk($sformatf("rnd%0d flags", i), {29'd0, fetch_valid, flush, halted},
                {29'd0, (m_mode == 1), (m_mode == 2), (m_mode == 3)});
            chk($sformatf("rnd%0d link", i), link_addr, r + 32'd1);
            if (i % 100 == 0)
                $display("rnd %0d: pc=%h state=%0d", i, pc, state);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the word-addressed core.
- Selects the next PC from one of four sources: PC+1, branch target, J-type jump target, or jump-register target.
- Forms the J-type address as {ex_pc[31:27], jump_field[26:0]}.
- On redirects, drives flush/bubble control to the fetch and decode stages; also handles boot and halt.

Parameters:
- RESET_VECTOR, 32'h00000000, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles flush stays high after a redirect (legal range 1..15).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  hazard unit: hold PC.
- imem_ready  in  1  instruction memory can accept the current fetch.
- ex_pc  in  32  PC of the instruction in EX.
- br_taken  in  1  branch in EX resolved taken.
- br_target  in  32  absolute branch target.
- jump  in  1  J-type jump (j/jal) in EX.
- jump_field  in  27  target field of the J-type instruction.
- jr  in  1  jump-register in EX.
- jr_target  in  32  register value for jr.
- halt  in  1  halt instruction reached EX.
- pc  out  32  current fetch address.
- fetch_valid  out  1  pc is a valid fetch this cycle.
- flush  out  1  kill IF/ID contents.
- link_addr  out  32  ex_pc+1 (jal return address), combinational.
- halted  out  1  core halted.
- state  out  2  BOOT=0, FETCH=1, REDIRECT=2, HALT=3.

Behaviour:
- Reset (reset==0 at a clock edge), overriding everything:
  - pc=RESET_VECTOR, state=BOOT, flush=0, halted=0, flush counter=0.
  - fetch_valid=0 throughout reset.
- BOOT: fetch_valid=0 and pc held for exactly one cycle, then FETCH. Redirect and halt inputs are ignored in BOOT.
- FETCH: fetch_valid=1. Next-PC priority, highest first:
  - halt: state goes to HALT, pc held.
  - jr: pc <= jr_target.
  - jump: pc <= {ex_pc[31:27], jump_field}.
  - br_taken: pc <= br_target.
  - stall or !imem_ready: pc held.
  - otherwise: pc <= pc+1, modulo 2^32 (32'hFFFFFFFF wraps to 0).
- Redirects:
  - Any of jr, jump or br_taken in FETCH takes effect even while stall or !imem_ready is asserted.
  - On a redirect: state goes to REDIRECT, flush counter is loaded with FLUSH_CYCLES, flush is registered high from the next cycle.
- REDIRECT:
  - flush=1, fetch_valid=0, pc held at the target.
  - Counter decrements each cycle; when it reaches 1, the next state is FETCH and flush returns to 0.
  - Exactly FLUSH_CYCLES cycles with flush=1.
  - jr, jump, br_taken and halt are ignored here, because EX holds a flushed bubble.
- HALT: absorbing until reset. halted=1, fetch_valid=0, flush=0, pc frozen.
- Multiple redirects in one cycle: resolved by the priority order above. Redirect with stall: redirect wins.
- link_addr = ex_pc+1 (mod 2^32) at all times, independent of state.
- All outputs except link_addr are registered or decoded from registered state; no combinational path from inputs to pc, flush or fetch_valid.

Test Plan:
- Boot: reset low for 3 cycles, then high.
  - During reset: pc=0, state=0.
  - First cycle after release: fetch_valid=0.
  - Following cycles: pc = 0, 1, 2, 3 with fetch_valid=1.
- Jump formation and flush: in FETCH, jump=1, ex_pc=32'hF8000010, jump_field=27'h2012529.
  - Next cycle: pc=32'hFA012529, state=2.
  - flush=1 for exactly 2 cycles, then FETCH.
  - pc then increments to 32'hFA01252A; link_addr=32'hF8000011 while ex_pc is held.
- Priority: jr=1 (jr_target=32'h100), jump=1 and br_taken=1 (br_target=32'h200), with stall=1, in the same cycle.
  - Required: pc=32'h100 and a redirect sequence starts.
- Stall and imem backpressure:
  - stall=1 for 4 cycles: pc constant.
  - imem_ready=0 for 2 cycles: pc constant.
  - On release: pc resumes +1.
  - Wrap check: pc=32'hFFFFFFFF advances to 32'h0.
- Ignored redirect and halt:
  - br_taken=1 while in REDIRECT: no pc change, and the flush count is not restarted.
  - halt=1 in FETCH: state=3, halted=1, pc frozen for 20 cycles despite jump=1 pulses.
  - reset mid-HALT: returns to BOOT with pc=RESET_VECTOR.
- Reset mid-REDIRECT: reset asserted on the 1st flush cycle.
  - Next edge: flush=0, state=0, pc=RESET_VECTOR.
